// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one uart_tx serializer between
// NUM_REQ byte producers, with a start-to-done watchdog.
// Optional feature macro: UART_ARB_ID_TAG_EN -- when defined, each grant
// sends a header byte {5'b10100, grant_id} ahead of the payload byte.
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 131072
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [8*NUM_REQ-1:0]   req_data,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic                   utx_start,
  output logic [7:0]             utx_data,
  input  logic                   utx_done,
  output logic                   busy,
  output logic [2:0]             grant_id,
  output logic                   timeout_err
);

  // A zero timeout disables the watchdog; keep a 1-bit counter so widths stay legal.
  localparam int              CNT_W    = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam bit              WD_EN    = (TIMEOUT_CYCLES > 0);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [2:0]      LAST_RST = 3'(NUM_REQ - 1);
  localparam logic [3:0]      NUM_REQ4 = 4'(NUM_REQ);

`ifdef UART_ARB_ID_TAG_EN
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_WAIT = 2'd2,
    ST_HDR  = 2'd3
  } state_e;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_WAIT = 2'd2
  } state_e;
`endif

  state_e           state_q;
  logic [2:0]       last_grant_q;
  logic [2:0]       grant_id_q;
  logic [7:0]       utx_data_q;
  logic             busy_q;
  logic             utx_start_q;
  logic             timeout_err_q;
  logic [CNT_W-1:0] wd_cnt_q;
  logic [CNT_W-1:0] wd_cnt_d;
  logic             wd_expire;
`ifdef UART_ARB_ID_TAG_EN
  logic [7:0]       payload_q;
  logic             hdr_phase_q;
`endif

  // Padded views let a 3-bit requester index address any legal NUM_REQ.
  logic [7:0]       valid_pad;
  logic [63:0]      data_pad;
  logic [3:0]       scan_idx;
  logic             sel_found;
  logic [2:0]       sel_idx;
  logic [7:0]       sel_byte;

  // Round-robin pick: first valid requester after last_grant, wrapping.
  always_comb begin
    valid_pad = 8'(req_valid);
    data_pad  = 64'(req_data);
    sel_found = 1'b0;
    sel_idx   = 3'd0;
    scan_idx  = 4'd0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      scan_idx = {1'b0, last_grant_q} + 4'(k);
      if (scan_idx >= NUM_REQ4) begin
        scan_idx = scan_idx - NUM_REQ4;
      end else begin
        scan_idx = scan_idx;
      end
      if (!sel_found && valid_pad[scan_idx[2:0]]) begin
        sel_found = 1'b1;
        sel_idx   = scan_idx[2:0];
      end else begin
        sel_found = sel_found;
      end
    end
    sel_byte = data_pad[{sel_idx, 3'b000} +: 8];
  end

  // Accept strobe is combinational so the byte is taken on the same edge it is offered.
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (rst_n && (state_q == ST_IDLE) && sel_found && (sel_idx == 3'(i))) begin
        req_ready[i] = 1'b1;
      end else begin
        req_ready[i] = 1'b0;
      end
    end
  end

  // Saturating watchdog increment and expiry detect for the current WAIT cycle.
  always_comb begin
    if (wd_cnt_q == CNT_MAX) begin
      wd_cnt_d = wd_cnt_q;
    end else begin
      wd_cnt_d = wd_cnt_q + CNT_W'(1);
    end
    wd_expire = WD_EN && (wd_cnt_d == TO_LIMIT);
  end

  // Arbiter FSM with registered outputs; utx_done outside WAIT is ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      last_grant_q  <= LAST_RST;
      grant_id_q    <= 3'd0;
      utx_data_q    <= 8'h00;
      busy_q        <= 1'b0;
      utx_start_q   <= 1'b0;
      timeout_err_q <= 1'b0;
      wd_cnt_q      <= '0;
`ifdef UART_ARB_ID_TAG_EN
      payload_q     <= 8'h00;
      hdr_phase_q   <= 1'b0;
`endif
    end else begin
      utx_start_q   <= 1'b0;
      timeout_err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (sel_found) begin
            grant_id_q  <= sel_idx;
            busy_q      <= 1'b1;
            utx_start_q <= 1'b1;
            state_q     <= ST_SEND;
`ifdef UART_ARB_ID_TAG_EN
            utx_data_q  <= {5'b10100, sel_idx};
            payload_q   <= sel_byte;
            hdr_phase_q <= 1'b1;
`else
            utx_data_q  <= sel_byte;
`endif
          end
        end
        ST_SEND: begin
          wd_cnt_q <= '0;
          state_q  <= ST_WAIT;
        end
        ST_WAIT: begin
          if (utx_done) begin
`ifdef UART_ARB_ID_TAG_EN
            if (hdr_phase_q) begin
              hdr_phase_q <= 1'b0;
              state_q     <= ST_HDR;
            end else begin
              last_grant_q <= grant_id_q;
              busy_q       <= 1'b0;
              state_q      <= ST_IDLE;
            end
`else
            last_grant_q <= grant_id_q;
            busy_q       <= 1'b0;
            state_q      <= ST_IDLE;
`endif
          end else if (wd_expire) begin
            // Stuck serializer: drop the byte (or the whole tagged pair) and move on.
            timeout_err_q <= 1'b1;
            last_grant_q  <= grant_id_q;
            busy_q        <= 1'b0;
            state_q       <= ST_IDLE;
`ifdef UART_ARB_ID_TAG_EN
            hdr_phase_q   <= 1'b0;
`endif
          end else begin
            wd_cnt_q <= wd_cnt_d;
          end
        end
`ifdef UART_ARB_ID_TAG_EN
        ST_HDR: begin
          utx_data_q  <= payload_q;
          utx_start_q <= 1'b1;
          state_q     <= ST_SEND;
        end
`endif
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign utx_start   = utx_start_q;
  assign utx_data    = utx_data_q;
  assign busy        = busy_q;
  assign grant_id    = grant_id_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed and randomized grants checked against a
// transaction-level round-robin model, plus watchdog and reset scenarios.
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int TO = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic [N-1:0] req_valid = '0;
  logic [8*N-1:0] req_data = '0;
  logic [N-1:0] req_ready;
  logic         utx_start;
  logic [7:0]   utx_data;
  logic         utx_done = 1'b0;
  logic         busy;
  logic [2:0]   grant_id;
  logic         timeout_err;

  int n_assert = 0;
  int n_fail   = 0;
  int m_last   = N - 1;  // model: last requester released
  int m_gid    = 0;      // model: value grant_id should show while idle

  uart_tx_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .utx_start(utx_start), .utx_data(utx_data), .utx_done(utx_done),
    .busy(busy), .grant_id(grant_id), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Round-robin rule: scan last+1, last+2, ... modulo N; first requester with a byte wins.
  function automatic int pick(input logic [N-1:0] v, input int last);
    for (int k = 1; k <= N; k++) begin
      if (v[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, 32'(req_ready), 32'd0);
    check({tag, "_start"}, 32'(utx_start), 32'd0);
    check({tag, "_data"},  32'(utx_data), 32'd0);
    check({tag, "_busy"},  32'(busy), 32'd0);
    check({tag, "_gid"},   32'(grant_id), 32'd0);
    check({tag, "_tmo"},   32'(timeout_err), 32'd0);
  endtask

  // Entered at negedge+1 of a SEND cycle; serializer model answers after 'delay'
  // WAIT cycles, or never when 'hang' is set.
  task automatic send_phase(input logic [7:0] b, input int id, input int delay,
                            input bit hang, input bit spurious, input bit last);
    int w;
    bit found;
    check("send_start", 32'(utx_start), 32'd1);
    check("send_data", 32'(utx_data), 32'(b));
    check("send_busy", 32'(busy), 32'd1);
    check("send_gid", 32'(grant_id), 32'(id));
    if (spurious) utx_done = 1'b1;
    if (hang) begin
      w = 0;
      found = 1'b0;
      while (!found && w < 40) begin
        @(negedge clk); utx_done = 1'b0; #1;
        if (timeout_err === 1'b1) found = 1'b1;
        else w++;
      end
      check("wd_fired", 32'(found), 32'd1);
      check("wd_cycles_into_wait", 32'(w), 32'(TO));
      check("wd_busy_drop", 32'(busy), 32'd0);
      @(negedge clk); #1;
      check("wd_single_pulse", 32'(timeout_err), 32'd0);
    end else begin
      for (int c = 0; c < delay; c++) begin
        @(negedge clk); utx_done = 1'b0; #1;
        check("wait_start_low", 32'(utx_start), 32'd0);
        check("wait_data_hold", 32'(utx_data), 32'(b));
        check("wait_busy", 32'(busy), 32'd1);
        check("wait_no_ready", 32'(req_ready), 32'd0);
        check("wait_no_tmo", 32'(timeout_err), 32'd0);
      end
      @(negedge clk); utx_done = 1'b1; req_valid = '0; #1;
      check("done_cycle_busy", 32'(busy), 32'd1);
      @(negedge clk); utx_done = 1'b0; #1;
      check("release_busy", 32'(busy), last ? 32'd0 : 32'd1);
      check("release_start", 32'(utx_start), 32'd0);
    end
  endtask

  // Entered at negedge+1 of an IDLE cycle; offers bytes, follows one whole grant.
  task automatic grant(input logic [N-1:0] v, input logic [31:0] d, input int delay,
                       input bit hang, input bit spurious);
    int sel;
    logic [7:0] pay;
    logic [7:0] hdr;
    logic [N-1:0] exp_rdy;
    sel = pick(v, m_last);
    req_valid = v;
    req_data  = d;
    #1;
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_gid", 32'(grant_id), 32'(m_gid));
    exp_rdy = '0;
    exp_rdy[sel] = 1'b1;
    check("req_ready_onehot", 32'(req_ready), 32'(exp_rdy));
    pay = d[sel*8 +: 8];
    hdr = 8'hA0 + 8'(sel);
    @(negedge clk);
    req_data = ~d;
    if (hang) req_valid = '0;
    #1;
    check("ready_single_pulse", 32'(req_ready), 32'd0);
`ifdef UART_ARB_ID_TAG_EN
    send_phase(hdr, sel, delay, hang, spurious, 1'b0);
    if (!hang) begin
      check("hdr_busy_held", 32'(busy), 32'd1);
      check("hdr_no_ready", 32'(req_ready), 32'd0);
      @(negedge clk); #1;
      send_phase(pay, sel, delay, 1'b0, 1'b0, 1'b1);
    end
`else
    check("hdr_unused", 32'(hdr[7:3]), 32'h14);
    send_phase(pay, sel, delay, hang, spurious, 1'b1);
`endif
    m_last = sel;
    m_gid  = sel;
  endtask

  initial begin
    #200000;
    $display("FAIL sim_time_limit: observed timeout expected completion");
    $fatal(1, "simulation time limit");
  end

  initial begin
    logic [N-1:0] rv;
    // Asynchronous reset, checked before any clock edge.
    #2 rst_n = 1'b0;
    #2 check_reset_outputs("reset");
    req_valid = '1;
    #1 check("reset_ready_gated", 32'(req_ready), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    req_valid = '0;
    #1;
    // Quiet idle and a stray done pulse in IDLE.
    repeat (2) begin
      @(negedge clk); #1;
      check("idle_quiet_busy", 32'(busy), 32'd0);
      check("idle_quiet_ready", 32'(req_ready), 32'd0);
    end
    @(negedge clk); utx_done = 1'b1;
    @(negedge clk); utx_done = 1'b0; #1;
    check("idle_done_ignored_busy", 32'(busy), 32'd0);
    check("idle_done_ignored_start", 32'(utx_start), 32'd0);

    // Single requester 0 with 0x5A.
    grant(4'b0001, 32'h0000005A, 3, 1'b0, 1'b0);
    // All requesters continuously valid: 1,2,3,0,1 follows from last=0.
    for (int i = 0; i < 5; i++) begin
      grant(4'b1111, 32'h13121110, int'($urandom_range(0, 12)), 1'b0, 1'b0);
    end
    // last_grant=2 then 0101: scan 3,0 -> 0.
    grant(4'b0100, $urandom, 2, 1'b0, 1'b0);
    grant(4'b0101, $urandom, 1, 1'b0, 1'b0);
    // Randomized traffic; one grant sees a stray done while in SEND.
    for (int i = 0; i < 12; i++) begin
      rv = 4'($urandom_range(1, 15));
      if (i == 3) grant(rv, $urandom, 5, 1'b0, 1'b1);
      else        grant(rv, $urandom, int'($urandom_range(0, 12)), 1'b0, 1'b0);
    end
    // Serializer never completes: watchdog abort, then the next requester is served.
    grant(4'b0010, $urandom, 0, 1'b1, 1'b0);
    grant(4'b1111, $urandom, 4, 1'b0, 1'b0);
    // Reset during WAIT.
    req_valid = 4'b1000;
    req_data  = $urandom;
    @(negedge clk); #1;
    check("rst_test_send", 32'(utx_start), 32'd1);
    @(negedge clk); #1;
    check("rst_test_wait_busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("midframe_reset");
    @(negedge clk);
    rst_n = 1'b1;
    req_valid = '0;
    m_last = N - 1;
    m_gid  = 0;
    #1;
    grant(4'b1111, $urandom, 2, 1'b0, 1'b0);
    grant(4'b1111, $urandom, 0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
